// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT coefficient router.
// Provides default transform sizing, the coefficient/stage types and the router FSM states.
package ntt_pkg;

  localparam int unsigned COEFF_W = 30;
  localparam int unsigned LOG_N   = 12;

  typedef logic [COEFF_W-1:0]       coeff_t;
  typedef logic [$clog2(LOG_N)-1:0] stage_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } router_state_e;

endpackage

// File: rtl/ntt_stage_router_if.sv
// Beat-level bus between butterfly cores, coefficient memories and the final-result consumer.
// Signals:
//   in_valid/in_ready/in_data/in_addr      butterfly results into the router
//   loop_valid/loop_data/loop_addr         loop-back memory writes (no backpressure)
//   out_valid/out_ready/out_data/out_addr  final-stage results with backpressure
// Data is packed [core][lane][bit]. The router uses the slave modport; the source side uses master.
interface ntt_stage_router_if #(
  parameter int unsigned LOG_CORE_COUNT = 5,
  parameter int unsigned COEFF_W        = ntt_pkg::COEFF_W,
  parameter int unsigned ADDR_W         = ntt_pkg::LOG_N - 5 - 1
);
  localparam int unsigned C = 2 ** LOG_CORE_COUNT;

  logic                            in_valid;
  logic                            in_ready;
  logic [C-1:0][1:0][COEFF_W-1:0]  in_data;
  logic [ADDR_W-1:0]               in_addr;

  logic                            loop_valid;
  logic [C-1:0][1:0][COEFF_W-1:0]  loop_data;
  logic [ADDR_W-1:0]               loop_addr;

  logic                            out_valid;
  logic                            out_ready;
  logic [C-1:0][1:0][COEFF_W-1:0]  out_data;
  logic [ADDR_W-1:0]               out_addr;

  modport master (
    output in_valid, in_data, in_addr, out_ready,
    input  in_ready, loop_valid, loop_data, loop_addr, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_data, in_addr, out_ready,
    output in_ready, loop_valid, loop_data, loop_addr, out_valid, out_data, out_addr
  );

endinterface

// File: rtl/ntt_router_xbar.sv
// Combinational cross-core exchange for loop-back writes.
// Ports:
//   tn_i    next-stage butterfly distance (log2)
//   data_i  [core][lane] butterfly results
//   data_o  [core][lane] permuted data
// For 1 <= tn <= LOG_CORE_COUNT the cores pair up across bit b = tn-1 of the core index:
// the lower core of a pair collects both lane-0 values, the upper core both lane-1 values.
// Any other distance passes data straight through.
module ntt_router_xbar #(
  parameter int unsigned LOG_CORE_COUNT = 5,
  parameter int unsigned COEFF_W        = 30,
  parameter int unsigned TnW            = 4
) (
  input  logic [TnW-1:0]                                 tn_i,
  input  logic [2**LOG_CORE_COUNT-1:0][1:0][COEFF_W-1:0] data_i,
  output logic [2**LOG_CORE_COUNT-1:0][1:0][COEFF_W-1:0] data_o
);
  localparam int unsigned C = 2 ** LOG_CORE_COUNT;

  logic                      exch;
  logic [LOG_CORE_COUNT-1:0] mask;

  assign exch = (tn_i != '0) && (tn_i <= TnW'(LOG_CORE_COUNT));
  // One-hot selector of the partner bit; zero when no exchange happens.
  assign mask = exch ? (LOG_CORE_COUNT'(1) << (tn_i - 1'b1)) : '0;

  for (genvar k = 0; k < C; k++) begin : g_core
    localparam logic [LOG_CORE_COUNT-1:0] KIdx = LOG_CORE_COUNT'(k);
    logic [LOG_CORE_COUNT-1:0] partner;
    logic                      upper;

    assign partner = KIdx ^ mask;
    assign upper   = |(KIdx & mask);

    assign data_o[k][0] = (exch && upper)  ? data_i[partner][1] : data_i[k][0];
    assign data_o[k][1] = (exch && !upper) ? data_i[partner][0] : data_i[k][1];
  end

endmodule

// File: rtl/ntt_stage_router.sv
// Stage-sequenced coefficient router between butterfly cores and coefficient memories.
// Owns the stage/beat schedule of one transform, permutes non-final results into loop-back
// writes (one-cycle latency) and presents final-stage results on a backpressured port.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin transform (accepted only in IDLE)
//   inverse       Gentleman-Sande order, sampled at accepted start (NTT_ROUTER_INTT_EN only)
//   busy          high while running
//   done          pulses in the cycle the last final beat completes its out handshake
//   stage_log_t   current butterfly distance log2 t (0 when idle)
//   bus           ntt_stage_router_if slave: in_*, loop_*, out_* beat channels
// Build option: define NTT_ROUTER_INTT_EN to add the inverse-order input.
module ntt_stage_router #(
  parameter int unsigned LOG_CORE_COUNT = 5,
  parameter int unsigned LOG_N          = ntt_pkg::LOG_N,
  parameter int unsigned COEFF_W        = ntt_pkg::COEFF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef NTT_ROUTER_INTT_EN
  input  logic                     inverse,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG_N)-1:0] stage_log_t,
  ntt_stage_router_if.slave        bus
);
  import ntt_pkg::*;

  localparam int unsigned C      = 2 ** LOG_CORE_COUNT;
  localparam int unsigned ADDR_W = LOG_N - LOG_CORE_COUNT - 1;
  localparam int unsigned StW    = $clog2(LOG_N);
  localparam int unsigned TnW    = $clog2(LOG_N + 1);

  localparam logic [ADDR_W-1:0] LastBeat  = '1;
  localparam logic [StW-1:0]    LastStage = StW'(LOG_N - 1);

  typedef logic [C-1:0][1:0][COEFF_W-1:0] data_t;

  router_state_e     state_q, state_d;
  logic [StW-1:0]    stage_q, stage_d;
  logic [ADDR_W-1:0] beat_q, beat_d;

  logic              loop_valid_q;
  data_t             loop_data_q;
  logic [ADDR_W-1:0] loop_addr_q;
  logic              out_valid_q;
  logic              out_last_q;
  data_t             out_data_q;
  logic [ADDR_W-1:0] out_addr_q;

  logic              final_stage;
  logic              last_beat;
  logic              in_ready_int;
  logic              accept;
  logic              start_acc;
  logic [TnW-1:0]    tn;
  data_t             xbar_data;

`ifdef NTT_ROUTER_INTT_EN
  logic inv_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (start_acc) begin
      inv_q <= inverse;
    end
  end
`else
  logic inv_q;
  assign inv_q = 1'b0;
`endif

  assign final_stage  = (stage_q == LastStage);
  assign last_beat    = (beat_q == LastBeat);
  // Final stage stalls while an unconsumed result sits in the output register.
  assign in_ready_int = (state_q == RUN) && (!final_stage || !out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && in_ready_int;
  assign start_acc    = (state_q == IDLE) && start;
  // Distance of the stage that will consume the loop-back writes.
  assign tn           = inv_q ? (TnW'(stage_q) + 1'b1) : (TnW'(LOG_N - 2) - TnW'(stage_q));

  ntt_router_xbar #(
    .LOG_CORE_COUNT (LOG_CORE_COUNT),
    .COEFF_W        (COEFF_W),
    .TnW            (TnW)
  ) u_xbar (
    .tn_i   (tn),
    .data_i (bus.in_data),
    .data_o (xbar_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      beat_q  <= beat_d;
    end
  end

  // Next state and schedule counters.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          stage_d = '0;
          beat_d  = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_beat) begin
            beat_d = '0;
            if (final_stage) begin
              state_d = IDLE;
              stage_d = '0;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy           = (state_q == RUN);
    stage_log_t    = '0;
    if (state_q == RUN) begin
      stage_log_t = inv_q ? stage_q : (LastStage - stage_q);
    end
    done           = out_valid_q && bus.out_ready && out_last_q;
    bus.in_ready   = in_ready_int;
    bus.loop_valid = loop_valid_q;
    bus.loop_data  = loop_data_q;
    bus.loop_addr  = loop_addr_q;
    bus.out_valid  = out_valid_q;
    bus.out_data   = out_data_q;
    bus.out_addr   = out_addr_q;
  end

  // Loop-back write register.
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_valid_q <= 1'b0;
      loop_data_q  <= '0;
      loop_addr_q  <= '0;
    end else begin
      loop_valid_q <= accept && !final_stage;
      if (accept && !final_stage) begin
        loop_data_q <= xbar_data;
        loop_addr_q <= bus.in_addr;
      end
    end
  end

  // Final-result register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else if (accept && final_stage) begin
      out_valid_q <= 1'b1;
      out_last_q  <= last_beat;
      out_data_q  <= bus.in_data;
      out_addr_q  <= bus.in_addr;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

endmodule
